// File: rtl/alu_sub_sequencer.sv
// alu_sub_sequencer: round-robin shared WIDTH-bit subtractor, one or two borrow-chained passes, owns NZCV
module alu_sub_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [2*WIDTH-1:0] req0_a,
   input  logic [2*WIDTH-1:0] req0_b,
   input  logic               req0_wide,
   input  logic               req0_s,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [2*WIDTH-1:0] req1_a,
   input  logic [2*WIDTH-1:0] req1_b,
   input  logic               req1_wide,
   input  logic               req1_s,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_id,
   output logic [2*WIDTH-1:0] rsp_result,
   output logic [3:0]         rsp_flags,
   output logic [3:0]         flags_out,
   output logic               busy
);
   typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;
   state_t state, state_nx;
   logic last1, g0, g1, accept, hs;
   logic [2*WIDTH-1:0] a_r, b_r, res_d;
   logic wide_r, s_r, id_r;
   logic [WIDTH-1:0] lo_r, hi_r, lo_d, hi_d;
   logic bl_r, vl_r, bh_r, vh_r, bl_d, bh_d, vl_d, vh_d;
   logic [3:0] flg_d;
   always_comb begin
      g0 = req0_valid & (~req1_valid | last1);
      g1 = req1_valid & ~g0;
      req0_ready = (state == IDLE) & g0;
      req1_ready = (state == IDLE) & g1;
      accept = req0_ready | req1_ready;
      hs = rsp_valid & rsp_ready;
      {bl_d, lo_d} = {1'b0, a_r[WIDTH-1:0]} - {1'b0, b_r[WIDTH-1:0]};
      {bh_d, hi_d} = {1'b0, a_r[2*WIDTH-1:WIDTH]} - {1'b0, b_r[2*WIDTH-1:WIDTH]} - {{WIDTH{1'b0}}, bl_r};
      vl_d = (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (lo_d[WIDTH-1] ^ a_r[WIDTH-1]);
      vh_d = (a_r[2*WIDTH-1] ^ b_r[2*WIDTH-1]) & (hi_d[WIDTH-1] ^ a_r[2*WIDTH-1]);
      res_d = wide_r ? {hi_r, lo_r} : {{WIDTH{lo_r[WIDTH-1]}}, lo_r};
      flg_d = wide_r ? {hi_r[WIDTH-1], ~|{hi_r, lo_r}, ~bh_r, vh_r}
                     : {lo_r[WIDTH-1], ~|lo_r, ~bl_r, vl_r};
      state_nx = (state == IDLE) ? (accept ? LO : IDLE) :
                 (state == LO)   ? (wide_r ? HI : RESP) :
                 (state == HI)   ? RESP :
                 (hs ? IDLE : RESP);
   end
   assign busy = (state != IDLE);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last1      <= 1'b1;
         a_r        <= '0;
         b_r        <= '0;
         wide_r     <= 1'b0;
         s_r        <= 1'b0;
         id_r       <= 1'b0;
         lo_r       <= '0;
         hi_r       <= '0;
         bl_r       <= 1'b0;
         vl_r       <= 1'b0;
         bh_r       <= 1'b0;
         vh_r       <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_flags  <= '0;
         flags_out  <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            a_r    <= req1_ready ? req1_a : req0_a;
            b_r    <= req1_ready ? req1_b : req0_b;
            wide_r <= req1_ready ? req1_wide : req0_wide;
            s_r    <= req1_ready ? req1_s : req0_s;
            id_r   <= req1_ready;
            last1  <= req1_ready;
         end
         if (state == LO) begin
            lo_r <= lo_d;
            bl_r <= bl_d;
            vl_r <= vl_d;
         end
         if (state == HI) begin
            hi_r <= hi_d;
            bh_r <= bh_d;
            vh_r <= vh_d;
         end
         // response registers load once on the first RESP cycle, then hold through any stall
         if (state == RESP && !rsp_valid) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= id_r;
            rsp_result <= res_d;
            rsp_flags  <= flg_d;
         end
         if (hs) begin
            rsp_valid <= 1'b0;
            if (s_r) flags_out <= rsp_flags;
         end
      end
   end
endmodule

// File: tb/tb_alu_sub_sequencer.sv
// tb_alu_sub_sequencer: vector table plus arbitration, stall and reset sequences, scoreboarded responses
module tb_alu_sub_sequencer;
   logic clk = 0, rst = 1;
   logic req0_valid = 0, req0_wide = 0, req0_s = 0, req0_ready;
   logic req1_valid = 0, req1_wide = 0, req1_s = 0, req1_ready;
   logic [63:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0, rsp_result;
   logic rsp_valid, rsp_ready = 0, rsp_id, busy;
   logic [3:0] rsp_flags, flags_out;

   alu_sub_sequencer #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_wide(req0_wide), .req0_s(req0_s),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_wide(req1_wide), .req1_s(req1_s),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_flags(rsp_flags), .flags_out(flags_out), .busy(busy)
   );

   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {logic id; logic [63:0] res; logic [3:0] flg; logic s;} exp_t;
   typedef struct {logic r; logic [63:0] a, b; logic w, s; logic [63:0] res; logic [3:0] flg;} vec_t;
   exp_t sb[$];
   vec_t vt[7];
   logic [3:0] mflags = 0;
   int nchk = 0, nfail = 0;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   task automatic drive(input logic r, input logic v, input logic [63:0] a, b, input logic w, s);
      if (r) begin
         req1_valid = v; req1_a = a; req1_b = b; req1_wide = w; req1_s = s;
      end else begin
         req0_valid = v; req0_a = a; req0_b = b; req0_wide = w; req0_s = s;
      end
   endtask

   task automatic wait_grant(input logic r);
      int n = 0;
      while (!(req0_ready | req1_ready) && n < 20) begin
         @(negedge clk); #1; n++;
      end
      chk("grant_seen", {63'd0, req0_ready | req1_ready}, 64'd1);
      chk("one_ready", {63'd0, req0_ready & req1_ready}, 64'd0);
      chk("grant_id", {63'd0, req1_ready}, {63'd0, r});
   endtask

   // pushes the expectation, waits for the grant, accepts, then scrambles the inputs
   task automatic issue(input logic r, input logic [63:0] a, b, input logic w, s,
                        input logic [63:0] res, input logic [3:0] flg, output int t0);
      sb.push_back('{r, res, flg, s});
      drive(r, 1'b1, a, b, w, s);
      #1;
      wait_grant(r);
      @(posedge clk); #1;
      t0 = cyc;
      drive(r, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, ~w, ~s);
   endtask

   task automatic respond(input logic w, input int t0, input int stall);
      exp_t e;
      int n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge clk); n++;
      end
      chk("rsp_valid_seen", {63'd0, rsp_valid}, 64'd1);
      chk("latency", 64'(cyc - t0), w ? 64'd3 : 64'd2);
      if (sb.size() == 0) begin
         chk("sb_nonempty", 64'd0, 64'd1);
         return;
      end
      e = sb.pop_front();
      chk("rsp_id", {63'd0, rsp_id}, {63'd0, e.id});
      chk("rsp_result", rsp_result, e.res);
      chk("rsp_flags", {60'd0, rsp_flags}, {60'd0, e.flg});
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("stall_valid", {63'd0, rsp_valid}, 64'd1);
         chk("stall_result", rsp_result, e.res);
         chk("stall_flags", {60'd0, rsp_flags}, {60'd0, e.flg});
         chk("stall_readys", {62'd0, req1_ready, req0_ready}, 64'd0);
         chk("stall_busy", {63'd0, busy}, 64'd1);
      end
      rsp_ready = 1;
      @(posedge clk); #1;
      rsp_ready = 0;
      if (e.s) mflags = e.flg;
      @(negedge clk);
      chk("flags_out", {60'd0, flags_out}, {60'd0, mflags});
      chk("rsp_valid_clr", {63'd0, rsp_valid}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      vt[0] = '{1'b0, 64'd5, 64'd3, 1'b0, 1'b1, 64'd2, 4'b0010};
      vt[1] = '{1'b1, 64'd3, 64'd5, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000};
      vt[2] = '{1'b1, 64'h8000_0000, 64'd1, 1'b0, 1'b0, 64'h0000_0000_7FFF_FFFF, 4'b0011};
      vt[3] = '{1'b0, 64'h0000_0001_0000_0000, 64'd1, 1'b1, 1'b1, 64'h0000_0000_FFFF_FFFF, 4'b0010};
      vt[4] = '{1'b0, 64'h1234_5678_0000_0000, 64'h1234_5678_0000_0000, 1'b1, 1'b1, 64'd0, 4'b0110};
      vt[5] = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 64'h8000_0000_0000_0000, 4'b1001};
      vt[6] = '{1'b1, 64'hDEAD_0000_0000_0000, 64'h8000_0000, 1'b0, 1'b0, 64'hFFFF_FFFF_8000_0000, 4'b1001};
      repeat (3) @(negedge clk);
      rst = 0;
      #1;
      chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_flags_out", {60'd0, flags_out}, 64'd0);
      chk("rst_rsp_result", rsp_result, 64'd0);
      chk("rst_rsp_id_flags", {59'd0, rsp_id, rsp_flags}, 64'd0);

      foreach (vt[i]) begin
         issue(vt[i].r, vt[i].a, vt[i].b, vt[i].w, vt[i].s, vt[i].res, vt[i].flg, t0);
         respond(vt[i].w, t0, 0);
      end

      // contention after a req1 grant: expect 0,1,0,1
      drive(1'b0, 1'b1, 64'd10, 64'd4, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 64'd4, 64'd10, 1'b0, 1'b0);
      #1;
      for (int i = 0; i < 4; i++) begin
         wait_grant(i[0]);
         if (i[0]) sb.push_back('{1'b1, 64'hFFFF_FFFF_FFFF_FFFA, 4'b1000, 1'b0});
         else sb.push_back('{1'b0, 64'd6, 4'b0010, 1'b0});
         @(posedge clk); #1;
         t0 = cyc;
         respond(1'b0, t0, 0);
         #1;
      end
      req0_valid = 0;
      req1_valid = 0;
      issue(1'b1, 64'd100, 64'd1, 1'b0, 1'b0, 64'd99, 4'b0010, t0);
      respond(1'b0, t0, 0);

      // stalled response with req1 waiting behind it
      issue(1'b0, 64'd9, 64'd9, 1'b0, 1'b1, 64'd0, 4'b0110, t0);
      drive(1'b1, 1'b1, 64'd1, 64'd2, 1'b0, 1'b0);
      respond(1'b0, t0, 5);
      #1;
      chk("post_stall_req1_ready", {63'd0, req1_ready}, 64'd1);
      sb.push_back('{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0});
      @(posedge clk); #1;
      t0 = cyc;
      req1_valid = 0;
      respond(1'b0, t0, 0);

      // reset in the middle of the high pass of a wide op from req0
      issue(1'b0, 64'h5_0000_0000, 64'h1_0000_0000, 1'b1, 1'b1, 64'h4_0000_0000, 4'b0010, t0);
      @(posedge clk);
      @(negedge clk);
      rst = 1;
      #1;
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      chk("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("midrst_flags_out", {60'd0, flags_out}, 64'd0);
      sb.delete();
      mflags = 0;
      @(negedge clk);
      rst = 0;
      repeat (4) begin
         @(negedge clk);
         chk("postrst_no_rsp", {62'd0, rsp_valid, busy}, 64'd0);
      end
      drive(1'b0, 1'b1, 64'd1, 64'd1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 64'd1, 64'd1, 1'b0, 1'b0);
      #1;
      chk("postrst_grant", {62'd0, req1_ready, req0_ready}, 64'd1);
      req0_valid = 0;
      req1_valid = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule
